// File: rtl/tpu_issue_controller.sv
// Instruction fetch/decode/issue controller for the TPU datapath.
// Walks FETCH -> DECODE -> ISSUE for every instruction word. A word is issued
// to its unit only once that unit can accept work. The controller also owns
// the double-buffer selects that SYNC flips.
module tpu_issue_controller #(
  parameter  int ADDR_W = 8,
  parameter  int ARG_W  = 8,
  parameter  int MODE_W = 4,
  localparam int IW     = 6 + 3*ARG_W + 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run,
  input  logic [ADDR_W-1:0]    start_pc,
  output logic [ADDR_W-1:0]    imem_addr,
  input  logic [IW-1:0]        imem_data,
  input  logic                 sys_busy,
  input  logic                 vpu_busy,
  input  logic                 dma_busy,
  input  logic                 wt_fifo_full,
  output logic                 sys_start,
  output logic [ARG_W-1:0]     sys_rows,
  output logic [ARG_W-1:0]     ub_rd_addr,
  output logic                 wt_fifo_wr,
  output logic                 vpu_start,
  output logic [MODE_W-1:0]    vpu_mode,
  output logic                 dma_start,
  output logic                 dma_dir,
  output logic [ARG_W-1:0]     dma_ub_addr,
  output logic [2*ARG_W-1:0]   dma_length,
  output logic [1:0]           dma_elem_sz,
  output logic                 wt_buf_sel,
  output logic                 acc_buf_sel,
  output logic                 pipeline_stall,
  output logic [1:0]           current_stage,
  output logic                 halted,
  output logic [ADDR_W-1:0]    pc,
  output logic                 err_illegal
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_ISSUE, S_HALTED
  } state_e;

  localparam logic [5:0] OP_NOP    = 6'h00;
  localparam logic [5:0] OP_MATMUL = 6'h01;
  localparam logic [5:0] OP_RDW    = 6'h02;
  localparam logic [5:0] OP_VPU    = 6'h03;
  localparam logic [5:0] OP_SYNC   = 6'h04;
  localparam logic [5:0] OP_LOAD   = 6'h05;
  localparam logic [5:0] OP_STORE  = 6'h06;
  localparam logic [5:0] OP_HALT   = 6'h07;

  state_e              state_q, state_d;
  logic [IW-1:0]       ir_q;
  logic [ADDR_W-1:0]   pc_q, imem_addr_q;
  logic                halted_q;
  logic                sys_start_q, wt_fifo_wr_q, vpu_start_q, dma_start_q;
  logic [ARG_W-1:0]    sys_rows_q, ub_rd_addr_q, dma_ub_addr_q;
  logic [MODE_W-1:0]   vpu_mode_q;
  logic                dma_dir_q;
  logic [2*ARG_W-1:0]  dma_length_q;
  logic [1:0]          dma_elem_sz_q;
  logic                wt_buf_sel_q, acc_buf_sel_q;

  // Instruction register fields, MSB first.
  logic [5:0]          opcode;
  logic [ARG_W-1:0]    arg1, arg2, arg3;
  logic [1:0]          flags;
  logic                res_ok;
  logic                illegal;

  assign opcode = ir_q[IW-1 -: 6];
  assign arg1   = ir_q[IW-7 -: ARG_W];
  assign arg2   = ir_q[IW-7-ARG_W -: ARG_W];
  assign arg3   = ir_q[IW-7-2*ARG_W -: ARG_W];
  assign flags  = ir_q[1:0];

  // Decide whether the latched instruction's target unit can accept it now.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    res_ok  = 1'b1;
    illegal = 1'b0;
    case (opcode)
      OP_NOP, OP_HALT:    res_ok = 1'b1;
      OP_MATMUL:          res_ok = !sys_busy;
      OP_RDW:             res_ok = !wt_fifo_full;
      OP_VPU:             res_ok = !vpu_busy;
      OP_LOAD, OP_STORE:  res_ok = !dma_busy;
      OP_SYNC:            res_ok = !sys_busy && !vpu_busy && !dma_busy;
      default:            illegal = 1'b1;
    endcase
  end

  // State register; reset dominates run.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic: fixed three-cycle walk, holding in ISSUE while stalled.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_HALTED: if (run) state_d = S_FETCH;
      S_FETCH:          state_d = S_DECODE;
      S_DECODE:         state_d = S_ISSUE;
      S_ISSUE: begin
        if (res_ok) state_d = (opcode == OP_HALT) ? S_HALTED : S_FETCH;
      end
      default:          state_d = S_IDLE;
    endcase
  end

  // Per-cycle status outputs derived from the current state.
  always_comb begin
    pipeline_stall = 1'b0;
    err_illegal    = 1'b0;
    current_stage  = 2'd0;
    case (state_q)
      S_FETCH:  current_stage = 2'd1;
      S_DECODE: current_stage = 2'd2;
      S_ISSUE: begin
        current_stage  = 2'd3;
        pipeline_stall = !res_ok;
        err_illegal    = illegal;
      end
      default:  current_stage = 2'd0;
    endcase
  end

  // Datapath: PC, fetch address, instruction register, issue pulses, payloads.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q          <= '0;
      imem_addr_q   <= '0;
      ir_q          <= '0;
      halted_q      <= 1'b0;
      sys_start_q   <= 1'b0;
      wt_fifo_wr_q  <= 1'b0;
      vpu_start_q   <= 1'b0;
      dma_start_q   <= 1'b0;
      sys_rows_q    <= '0;
      ub_rd_addr_q  <= '0;
      vpu_mode_q    <= '0;
      dma_dir_q     <= 1'b0;
      dma_ub_addr_q <= '0;
      dma_length_q  <= '0;
      dma_elem_sz_q <= '0;
      wt_buf_sel_q  <= 1'b0;
      acc_buf_sel_q <= 1'b0;
    end else begin
      // Start pulses last exactly one cycle unless re-fired below.
      sys_start_q  <= 1'b0;
      wt_fifo_wr_q <= 1'b0;
      vpu_start_q  <= 1'b0;
      dma_start_q  <= 1'b0;
      case (state_q)
        S_IDLE, S_HALTED: begin
          if (run) begin
            pc_q     <= start_pc;
            halted_q <= 1'b0;
          end
        end
        S_FETCH:  imem_addr_q <= pc_q;
        S_DECODE: ir_q        <= imem_data;
        S_ISSUE: begin
          if (res_ok) begin
            case (opcode)
              OP_MATMUL: begin
                sys_start_q  <= 1'b1;
                ub_rd_addr_q <= arg1;
                sys_rows_q   <= arg3;
              end
              OP_RDW:    wt_fifo_wr_q <= 1'b1;
              OP_VPU: begin
                vpu_start_q <= 1'b1;
                vpu_mode_q  <= arg3[MODE_W-1:0];
              end
              OP_LOAD, OP_STORE: begin
                dma_start_q   <= 1'b1;
                dma_dir_q     <= (opcode == OP_STORE);
                dma_ub_addr_q <= arg1;
                dma_length_q  <= {arg2, arg3};
                dma_elem_sz_q <= flags;
              end
              OP_SYNC: begin
                wt_buf_sel_q  <= !wt_buf_sel_q;
                acc_buf_sel_q <= !acc_buf_sel_q;
              end
              OP_HALT:   halted_q <= 1'b1;
              default:   ;
            endcase
            // HALT leaves the PC pointing at itself; everything else advances.
            if (opcode != OP_HALT) pc_q <= pc_q + ADDR_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign imem_addr   = imem_addr_q;
  assign pc          = pc_q;
  assign halted      = halted_q;
  assign sys_start   = sys_start_q;
  assign sys_rows    = sys_rows_q;
  assign ub_rd_addr  = ub_rd_addr_q;
  assign wt_fifo_wr  = wt_fifo_wr_q;
  assign vpu_start   = vpu_start_q;
  assign vpu_mode    = vpu_mode_q;
  assign dma_start   = dma_start_q;
  assign dma_dir     = dma_dir_q;
  assign dma_ub_addr = dma_ub_addr_q;
  assign dma_length  = dma_length_q;
  assign dma_elem_sz = dma_elem_sz_q;
  assign wt_buf_sel  = wt_buf_sel_q;
  assign acc_buf_sel = acc_buf_sel_q;

endmodule

// File: tb/tb_tpu_issue_controller.sv
// Self-checking bench for tpu_issue_controller: a table of single-instruction
// vectors plus hand-written multi-cycle sequences (stalls, SYNC, HALT, reset).
module tb_tpu_issue_controller;

  localparam int ADDR_W = 8;
  localparam int ARG_W  = 8;
  localparam int MODE_W = 4;
  localparam int IW     = 32;

  localparam logic [5:0] NOP = 6'h00, MATMUL = 6'h01, RDW = 6'h02, VPU = 6'h03,
                         SYNC = 6'h04, LOAD = 6'h05, STORE = 6'h06, HALT = 6'h07;

  logic                clk = 1'b0;
  logic                rst, run;
  logic [ADDR_W-1:0]   start_pc;
  logic [ADDR_W-1:0]   imem_addr;
  logic [IW-1:0]       imem_data;
  logic                sys_busy, vpu_busy, dma_busy, wt_fifo_full;
  logic                sys_start, wt_fifo_wr, vpu_start, dma_start, dma_dir;
  logic [ARG_W-1:0]    sys_rows, ub_rd_addr, dma_ub_addr;
  logic [MODE_W-1:0]   vpu_mode;
  logic [2*ARG_W-1:0]  dma_length;
  logic [1:0]          dma_elem_sz, current_stage;
  logic                wt_buf_sel, acc_buf_sel, pipeline_stall, halted, err_illegal;
  logic [ADDR_W-1:0]   pc;

  tpu_issue_controller #(.ADDR_W(ADDR_W), .ARG_W(ARG_W), .MODE_W(MODE_W)) dut (
    .clk(clk), .rst(rst), .run(run), .start_pc(start_pc),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .sys_busy(sys_busy), .vpu_busy(vpu_busy), .dma_busy(dma_busy),
    .wt_fifo_full(wt_fifo_full),
    .sys_start(sys_start), .sys_rows(sys_rows), .ub_rd_addr(ub_rd_addr),
    .wt_fifo_wr(wt_fifo_wr), .vpu_start(vpu_start), .vpu_mode(vpu_mode),
    .dma_start(dma_start), .dma_dir(dma_dir), .dma_ub_addr(dma_ub_addr),
    .dma_length(dma_length), .dma_elem_sz(dma_elem_sz),
    .wt_buf_sel(wt_buf_sel), .acc_buf_sel(acc_buf_sel),
    .pipeline_stall(pipeline_stall), .current_stage(current_stage),
    .halted(halted), .pc(pc), .err_illegal(err_illegal)
  );

  always #5 clk = ~clk;

  // Instruction memory: data for the registered address is visible in the
  // cycle after imem_addr was updated, i.e. during DECODE.
  logic [IW-1:0] imem [256];
  assign imem_data = imem[imem_addr];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [7:0] a1,
                                     input logic [7:0] a2, input logic [7:0] a3,
                                     input logic [1:0] fl);
    return {op, a1, a2, a3, fl};
  endfunction

  task automatic clear_imem();
    for (int i = 0; i < 256; i++) imem[i] = mk(NOP, 8'h00, 8'h00, 8'h00, 2'd0);
  endtask

  // Ends on a negedge with rst low and the DUT idle.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; run = 1'b0; start_pc = '0;
    sys_busy = 1'b0; vpu_busy = 1'b0; dma_busy = 1'b0; wt_fifo_full = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Called on a negedge; run is sampled on the next posedge. Returns one
  // negedge later, with the DUT in FETCH.
  task automatic start_run(input logic [7:0] spc);
    run = 1'b1; start_pc = spc;
    @(negedge clk);
    run = 1'b0;
  endtask

  typedef struct packed {
    logic [7:0]  spc;
    logic [31:0] instr;
    logic        err;
    logic [3:0]  pulses;   // {sys_start, wt_fifo_wr, vpu_start, dma_start}
    logic [7:0]  rows;
    logic [7:0]  ub;
    logic [3:0]  mode;
    logic        dir;
    logic [7:0]  dub;
    logic [15:0] len;
    logic [1:0]  esz;
    logic        sel;
    logic        hlt;
    logic [7:0]  pc;
  } vec_t;

  localparam int NV = 10;
  vec_t tv [NV];

  logic [73:0] all_outs;
  assign all_outs = {imem_addr, sys_start, sys_rows, ub_rd_addr, wt_fifo_wr, vpu_start,
                     vpu_mode, dma_start, dma_dir, dma_ub_addr, dma_length, dma_elem_sz,
                     wt_buf_sel, acc_buf_sel, pipeline_stall, current_stage, halted, pc,
                     err_illegal};

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int errs;
    logic saw_wr;

    //            spc    instr                                     err pulses   rows   ub     mode  dir  dub    len       esz   sel  hlt  pc
    tv[0] = '{8'h10, mk(MATMUL, 8'h20, 8'h00, 8'h08, 2'd0), 1'b0, 4'b1000, 8'h08, 8'h20, 4'h0, 1'b0, 8'h00, 16'h0000, 2'd0, 1'b0, 1'b0, 8'h11};
    tv[1] = '{8'h30, mk(RDW,    8'h12, 8'h34, 8'h56, 2'd3), 1'b0, 4'b0100, 8'h00, 8'h00, 4'h0, 1'b0, 8'h00, 16'h0000, 2'd0, 1'b0, 1'b0, 8'h31};
    tv[2] = '{8'h40, mk(VPU,    8'h01, 8'h02, 8'h5A, 2'd0), 1'b0, 4'b0010, 8'h00, 8'h00, 4'hA, 1'b0, 8'h00, 16'h0000, 2'd0, 1'b0, 1'b0, 8'h41};
    tv[3] = '{8'h50, mk(STORE,  8'h11, 8'h22, 8'h33, 2'd1), 1'b0, 4'b0001, 8'h00, 8'h00, 4'h0, 1'b1, 8'h11, 16'h2233, 2'd1, 1'b0, 1'b0, 8'h51};
    tv[4] = '{8'h60, mk(NOP,    8'hFF, 8'hFF, 8'hFF, 2'd3), 1'b0, 4'b0000, 8'h00, 8'h00, 4'h0, 1'b0, 8'h00, 16'h0000, 2'd0, 1'b0, 1'b0, 8'h61};
    tv[5] = '{8'h70, mk(6'h3F,  8'h20, 8'h00, 8'h08, 2'd0), 1'b1, 4'b0000, 8'h00, 8'h00, 4'h0, 1'b0, 8'h00, 16'h0000, 2'd0, 1'b0, 1'b0, 8'h71};
    tv[6] = '{8'hFF, mk(NOP,    8'h00, 8'h00, 8'h00, 2'd0), 1'b0, 4'b0000, 8'h00, 8'h00, 4'h0, 1'b0, 8'h00, 16'h0000, 2'd0, 1'b0, 1'b0, 8'h00};
    tv[7] = '{8'h80, mk(HALT,   8'h00, 8'h00, 8'h00, 2'd0), 1'b0, 4'b0000, 8'h00, 8'h00, 4'h0, 1'b0, 8'h00, 16'h0000, 2'd0, 1'b0, 1'b1, 8'h80};
    tv[8] = '{8'h90, mk(SYNC,   8'h00, 8'h00, 8'h00, 2'd0), 1'b0, 4'b0000, 8'h00, 8'h00, 4'h0, 1'b0, 8'h00, 16'h0000, 2'd0, 1'b1, 1'b0, 8'h91};
    tv[9] = '{8'hA0, mk(LOAD,   8'h40, 8'h01, 8'h00, 2'd2), 1'b0, 4'b0001, 8'h00, 8'h00, 4'h0, 1'b0, 8'h40, 16'h0100, 2'd2, 1'b0, 1'b0, 8'hA1};

    rst = 1'b1; run = 1'b0; start_pc = '0;
    sys_busy = 1'b0; vpu_busy = 1'b0; dma_busy = 1'b0; wt_fifo_full = 1'b0;
    clear_imem();

    // Reset state.
    do_reset();
    check("reset_outputs_zero", 64'($countones(all_outs)), 64'd0);

    // Table: each instruction run alone from a fresh reset, unstalled.
    for (int i = 0; i < NV; i++) begin
      clear_imem();
      do_reset();
      imem[tv[i].spc] = tv[i].instr;
      start_run(tv[i].spc);
      repeat (2) @(negedge clk);                 // ISSUE cycle
      check($sformatf("v%0d_stage_issue", i), 64'(current_stage), 64'd3);
      check($sformatf("v%0d_no_stall", i), 64'(pipeline_stall), 64'd0);
      check($sformatf("v%0d_err_illegal", i), 64'(err_illegal), 64'(tv[i].err));
      @(negedge clk);                            // three edges after run
      check($sformatf("v%0d_pulses", i), 64'({sys_start, wt_fifo_wr, vpu_start, dma_start}),
            64'(tv[i].pulses));
      check($sformatf("v%0d_payload", i),
            64'({sys_rows, ub_rd_addr, vpu_mode, dma_dir, dma_ub_addr, dma_length, dma_elem_sz}),
            64'({tv[i].rows, tv[i].ub, tv[i].mode, tv[i].dir, tv[i].dub, tv[i].len, tv[i].esz}));
      check($sformatf("v%0d_pc", i), 64'(pc), 64'(tv[i].pc));
      check($sformatf("v%0d_sel", i), 64'({wt_buf_sel, acc_buf_sel}), 64'({tv[i].sel, tv[i].sel}));
      check($sformatf("v%0d_halted", i), 64'(halted), 64'(tv[i].hlt));
      check($sformatf("v%0d_err_gone", i), 64'(err_illegal), 64'd0);
      @(negedge clk);
      check($sformatf("v%0d_pulses_one_cycle", i),
            64'({sys_start, wt_fifo_wr, vpu_start, dma_start}), 64'd0);
      check($sformatf("v%0d_next_imem_addr", i), 64'(imem_addr), 64'(tv[i].pc));
    end

    // LOAD stalled by dma_busy for 5 cycles.
    clear_imem();
    do_reset();
    imem[8'h20] = mk(LOAD, 8'h40, 8'h01, 8'h00, 2'd2);
    dma_busy = 1'b1;
    start_run(8'h20);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("load_stall_c%0d", i), 64'({pipeline_stall, dma_start}), 64'b10);
      if (i == 4) dma_busy = 1'b0;
      @(negedge clk);
    end
    check("load_dma_start", 64'(dma_start), 64'd1);
    check("load_payload", 64'({dma_dir, dma_ub_addr, dma_length, dma_elem_sz}),
          64'({1'b0, 8'h40, 16'h0100, 2'd2}));
    check("load_stall_clear", 64'(pipeline_stall), 64'd0);

    // Two SYNCs, the second held off by vpu_busy for 3 cycles.
    clear_imem();
    do_reset();
    imem[8'h00] = mk(SYNC, 8'h00, 8'h00, 8'h00, 2'd0);
    imem[8'h01] = mk(SYNC, 8'h00, 8'h00, 8'h00, 2'd0);
    start_run(8'h00);
    repeat (3) @(negedge clk);
    check("sync1_sel", 64'({wt_buf_sel, acc_buf_sel}), 64'b11);
    vpu_busy = 1'b1;
    repeat (2) @(negedge clk);                   // second SYNC in ISSUE
    for (int i = 0; i < 3; i++) begin
      check($sformatf("sync2_stall_c%0d", i), 64'({pipeline_stall, wt_buf_sel, acc_buf_sel}), 64'b111);
      if (i == 2) vpu_busy = 1'b0;
      @(negedge clk);
    end
    check("sync2_sel", 64'({pipeline_stall, wt_buf_sel, acc_buf_sel}), 64'b000);

    // NOP, illegal opcode, HALT; then restart from HALTED.
    clear_imem();
    do_reset();
    imem[8'hA0] = mk(NOP,   8'h00, 8'h00, 8'h00, 2'd0);
    imem[8'hA1] = mk(6'h3F, 8'hAA, 8'hBB, 8'hCC, 2'd1);
    imem[8'hA2] = mk(HALT,  8'h00, 8'h00, 8'h00, 2'd0);
    start_run(8'hA0);
    errs = 0;
    for (int k = 0; k < 30; k++) begin
      if (err_illegal) errs++;
      if (halted) break;
      @(negedge clk);
    end
    check("halt_reached", 64'(halted), 64'd1);
    check("illegal_pulse_count", 64'(errs), 64'd1);
    check("halt_pc", 64'(pc), 64'hA2);
    repeat (5) @(negedge clk);
    check("halt_sticky", 64'({halted, current_stage, err_illegal}), 64'b1000);
    imem[8'hB0] = mk(NOP, 8'h00, 8'h00, 8'h00, 2'd0);
    start_run(8'hB0);
    check("restart_state", 64'({halted, current_stage, pc}), 64'({1'b0, 2'd1, 8'hB0}));
    @(negedge clk);
    check("restart_fetch_addr", 64'(imem_addr), 64'hB0);

    // Reset while stalled on RD_WEIGHT, with selects set by an earlier SYNC.
    clear_imem();
    do_reset();
    imem[8'hBF] = mk(SYNC, 8'h00, 8'h00, 8'h00, 2'd0);
    imem[8'hC0] = mk(RDW,  8'h00, 8'h00, 8'h00, 2'd0);
    wt_fifo_full = 1'b1;
    start_run(8'hBF);
    repeat (3) @(negedge clk);
    check("rdw_pre_sel", 64'({wt_buf_sel, acc_buf_sel}), 64'b11);
    repeat (2) @(negedge clk);
    check("rdw_stalled", 64'({current_stage, pipeline_stall, wt_fifo_wr}), 64'b1110);
    rst = 1'b1;
    @(negedge clk);
    check("rst_stall_all_zero", 64'($countones(all_outs)), 64'd0);
    rst = 1'b0;
    wt_fifo_full = 1'b0;
    saw_wr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (wt_fifo_wr || current_stage != 2'd0) saw_wr = 1'b1;
    end
    check("rst_no_late_wr", 64'(saw_wr), 64'd0);

    // Simultaneous rst and run: reset wins.
    rst = 1'b1; run = 1'b1; start_pc = 8'h55;
    @(negedge clk);
    check("rst_beats_run", 64'({current_stage, pc}), 64'd0);
    rst = 1'b0; run = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
